// File: rtl/hpi_pkg.sv
// hpi_pkg: shared definitions for the HPI access controller.
//   state_t      - access sequencer states
//   HPI_*        - HPI register select encodings driven on otg_addr
//   cnt_width()  - bits needed for a phase down-counter
package hpi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    // A phase of length n loads n-1, which needs clog2(n) bits; keep at least one.
    function automatic int unsigned cnt_width(input int unsigned max_len);
        int unsigned w;
        w = $clog2(max_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hpi_sync2.sv
// hpi_sync2: two-flop synchronizer for an asynchronous level input.
//   clk   - destination clock
//   reset - asynchronous active-high reset, clears both flops
//   d     - asynchronous input
//   q     - synchronized level, two cycles behind d
module hpi_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hpi_access_ctrl.sv
// hpi_access_ctrl: sequences single read/write accesses onto an HPI bus
// through SETUP, STROBE, HOLD and RECOVER phases of parameterised length.
//   clk, reset          - clock, asynchronous active-high reset
//   req_*               - request channel (req_ready high only while idle)
//   resp_valid/rdata    - completion pulse and last read data
//   otg_*               - HPI pins (address, active-low strobes, data, oe)
//   otg_int / irq       - HPI interrupt in, processor interrupt out
// Build option: define HPI_INT_SYNC_EN to route otg_int through a two-flop
// synchronizer; otherwise irq follows otg_int combinationally.
module hpi_access_ctrl
    import hpi_pkg::*;
#(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 2,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    input  logic        otg_int,
    output logic        irq
);

    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || RECOVERY_CYC < 1) begin : g_bad_param
        $error("hpi_access_ctrl: every phase length parameter must be at least 1");
    end

    localparam int unsigned MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_B   = (HOLD_CYC > RECOVERY_CYC) ? HOLD_CYC : RECOVERY_CYC;
    localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = cnt_width(MAX_LEN);

    // Counters hold "cycles remaining minus one"; a phase ends when it reads zero.
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_STROBE  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RECOVER = CNT_W'(RECOVERY_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;

    // All pin outputs are registered and updated on the phase transition
    // so they change in the same cycle the new state becomes visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            wr_q         <= 1'b0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            otg_addr     <= '0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_out <= '0;
            otg_data_oe  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q         <= req_write;
                        otg_addr     <= req_addr;
                        otg_data_out <= req_wdata;
                        otg_data_oe  <= req_write;
                        otg_cs_n     <= 1'b0;
                        req_ready    <= 1'b0;
                        cnt          <= LD_SETUP;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        otg_rd_n <= wr_q;
                        otg_wr_n <= ~wr_q;
                        cnt      <= LD_STROBE;
                        state    <= STROBE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        otg_rd_n   <= 1'b1;
                        otg_wr_n   <= 1'b1;
                        resp_valid <= 1'b1;
                        if (!wr_q) begin
                            resp_rdata <= otg_data_in;
                        end
                        cnt   <= LD_HOLD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        otg_cs_n    <= 1'b1;
                        otg_data_oe <= 1'b0;
                        cnt         <= LD_RECOVER;
                        state       <= RECOVER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    otg_cs_n    <= 1'b1;
                    otg_rd_n    <= 1'b1;
                    otg_wr_n    <= 1'b1;
                    otg_data_oe <= 1'b0;
                    req_ready   <= 1'b1;
                    cnt         <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef HPI_INT_SYNC_EN
    hpi_sync2 u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (otg_int),
        .q     (irq)
    );
`else
    assign irq = otg_int;
`endif

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// tb_hpi_access_ctrl: directed bench for hpi_access_ctrl. Instance a uses
// default timing, instance b uses SETUP_CYC=3 / STROBE_CYC=4; both share the
// request inputs so each access exercises both timings side by side.
// Per-cycle pin values are logged as bit vectors (bit k-1 = cycle k after
// acceptance) and compared against hand-derived masks.
module tb_hpi_access_ctrl;
    import hpi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_addr;
    logic [15:0] req_wdata;
    logic [15:0] otg_data_in;
    logic        otg_int;

    logic        a_req_ready, a_resp_valid, a_cs_n, a_rd_n, a_wr_n, a_oe, a_irq;
    logic [15:0] a_resp_rdata, a_data_out;
    logic [1:0]  a_addr;
    logic        b_req_ready, b_resp_valid, b_cs_n, b_rd_n, b_wr_n, b_oe, b_irq;
    logic [15:0] b_resp_rdata, b_data_out;
    logic [1:0]  b_addr;

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    logic [15:0] a_cs, a_rd, a_wr, a_oe_v, a_rv, a_rdy;
    logic [15:0] b_cs, b_rd, b_wr, b_oe_v, b_rv, b_rdy;
    logic [15:0] a_rdata_c3, a_rdata_c4, a_dout_c1, b_rdata_c8;
    logic [1:0]  a_addr_c1;

    always #5 clk = ~clk;

    hpi_access_ctrl dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .otg_addr(a_addr), .otg_cs_n(a_cs_n), .otg_rd_n(a_rd_n), .otg_wr_n(a_wr_n),
        .otg_data_out(a_data_out), .otg_data_oe(a_oe), .otg_data_in(otg_data_in),
        .otg_int(otg_int), .irq(a_irq)
    );

    hpi_access_ctrl #(.SETUP_CYC(3), .STROBE_CYC(4)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .otg_addr(b_addr), .otg_cs_n(b_cs_n), .otg_rd_n(b_rd_n), .otg_wr_n(b_wr_n),
        .otg_data_out(b_data_out), .otg_data_oe(b_oe), .otg_data_in(otg_data_in),
        .otg_int(otg_int), .irq(b_irq)
    );

    // Strobe overlap and driving-while-reading are illegal at any time.
    always @(negedge clk) begin
        if (!a_rd_n && !a_wr_n) viol++;
        if (!b_rd_n && !b_wr_n) viol++;
        if (a_oe && !a_rd_n)    viol++;
        if (b_oe && !b_rd_n)    viol++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one request in cycle 0, keep req_valid high through cycle
    // hold_until, and log 16 cycles of pin activity for both instances.
    task automatic run_access(input string tag, input logic wr, input logic [1:0] addr,
                              input logic [15:0] data, input int unsigned hold_until);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        @(negedge clk);
        check({tag, "_rdy0_a"}, 32'(a_req_ready), 32'd1);
        check({tag, "_rdy0_b"}, 32'(b_req_ready), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k > hold_until) req_valid = 1'b0;
            @(negedge clk);
            a_cs[k-1] = a_cs_n;  a_rd[k-1] = a_rd_n;  a_wr[k-1] = a_wr_n;
            a_oe_v[k-1] = a_oe;  a_rv[k-1] = a_resp_valid;  a_rdy[k-1] = a_req_ready;
            b_cs[k-1] = b_cs_n;  b_rd[k-1] = b_rd_n;  b_wr[k-1] = b_wr_n;
            b_oe_v[k-1] = b_oe;  b_rv[k-1] = b_resp_valid;  b_rdy[k-1] = b_req_ready;
            if (k == 1) begin
                a_addr_c1 = a_addr;
                a_dout_c1 = a_data_out;
            end
            if (k == 3) a_rdata_c3 = a_resp_rdata;
            if (k == 4) a_rdata_c4 = a_resp_rdata;
            if (k == 8) b_rdata_c8 = b_resp_rdata;
        end
    endtask

    initial begin
        logic        rv_seen;
        logic [31:0] irq_exp;

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        otg_data_in = 16'hBEEF;
        otg_int     = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(a_req_ready), 32'd1);
        check("rst_strobes", {29'd0, a_cs_n, a_rd_n, a_wr_n}, 32'h7);
        check("rst_oe_rv_irq", {29'd0, a_oe, a_resp_valid, a_irq}, 32'h0);
        check("rst_data", {a_addr, a_data_out, 14'd0}, 32'h0);
        check("rst_rdata", 32'(a_resp_rdata), 32'h0);

        // Read DATA register, otg_data_in = 0xBEEF
        run_access("rd", 1'b0, HPI_DATA, 16'h0000, 0);
        check("rd_cs_a",    32'(a_cs),   32'hFFF0);
        check("rd_rd_a",    32'(a_rd),   32'hFFF9);
        check("rd_wr_a",    32'(a_wr),   32'hFFFF);
        check("rd_oe_a",    32'(a_oe_v), 32'h0000);
        check("rd_rv_a",    32'(a_rv),   32'h0008);
        check("rd_rdy_a",   32'(a_rdy),  32'hFFC0);
        check("rd_rdata_c3", 32'(a_rdata_c3), 32'h0000);
        check("rd_rdata_c4", 32'(a_rdata_c4), 32'hBEEF);
        check("rd_rd_b",    32'(b_rd),   32'hFF87);
        check("rd_cs_b",    32'(b_cs),   32'hFF00);
        check("rd_rv_b",    32'(b_rv),   32'h0080);
        check("rd_rdata_b", 32'(b_rdata_c8), 32'hBEEF);

        // Write ADDRESS register with 0x1234; read data must hold
        otg_data_in = 16'h5555;
        run_access("wr", 1'b1, HPI_ADDRESS, 16'h1234, 0);
        check("wr_cs_a",    32'(a_cs),   32'hFFF0);
        check("wr_wr_a",    32'(a_wr),   32'hFFF9);
        check("wr_rd_a",    32'(a_rd),   32'hFFFF);
        check("wr_oe_a",    32'(a_oe_v), 32'h000F);
        check("wr_rv_a",    32'(a_rv),   32'h0008);
        check("wr_rdy_a",   32'(a_rdy),  32'hFFC0);
        check("wr_addr_a",  32'(a_addr_c1), 32'h2);
        check("wr_dout_a",  32'(a_dout_c1), 32'h1234);
        check("wr_rdata_hold", 32'(a_resp_rdata), 32'hBEEF);
        check("wr_wr_b",    32'(b_wr),   32'hFF87);
        check("wr_oe_b",    32'(b_oe_v), 32'h00FF);
        check("wr_rdy_b",   32'(b_rdy),  32'hFC00);

        // Back-to-back: req_valid held through cycle 7
        run_access("b2b", 1'b1, HPI_MAILBOX, 16'hA5A5, 7);
        check("b2b_cs_a",  32'(a_cs),  32'hF870);
        check("b2b_rdy_a", 32'(a_rdy), 32'hE040);
        check("b2b_rv_a",  32'(a_rv),  32'h0408);
        check("b2b_cs_b",  32'(b_cs),  32'hFF00);
        check("b2b_rv_b",  32'(b_rv),  32'h0080);

        // Reset pulsed during STROBE of a write
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = HPI_STATUS; req_wdata = 16'h0F0F;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("arst_pre_wr", {30'd0, a_wr_n, a_cs_n}, 32'h0);
        reset = 1'b1;
        #1;
        check("arst_strobes_a", {29'd0, a_cs_n, a_rd_n, a_wr_n}, 32'h7);
        check("arst_oe_a", 32'(a_oe), 32'h0);
        check("arst_cs_b", 32'(b_cs_n), 32'h1);
        #5 reset = 1'b0;
        rv_seen = 1'b0;
        @(negedge clk);
        check("arst_ready", 32'(a_req_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            rv_seen = rv_seen | a_resp_valid | b_resp_valid;
            @(negedge clk);
        end
        check("arst_no_resp", 32'(rv_seen), 32'h0);

        // Interrupt path
`ifdef HPI_INT_SYNC_EN
        irq_exp = 32'd0;
`else
        irq_exp = 32'd1;
`endif
        @(posedge clk); #1;
        otg_int = 1'b1;
        #1 check("irq_c0", 32'(a_irq), irq_exp);
        @(posedge clk); #1;
        check("irq_c1", 32'(a_irq), irq_exp);
        @(posedge clk); #1;
        check("irq_c2", 32'(a_irq), 32'd1);
        otg_int = 1'b0;
        repeat (3) @(posedge clk);

        check("no_overlap", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hpi_access_ctrl.md
HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles with cs_n low and address/data valid before the strobe.
REQ-002 Parameter STROBE_CYC, default 2: cycles rd_n/wr_n is held low.
REQ-003 Parameter HOLD_CYC, default 1: cycles after strobe release with cs_n still low.
REQ-004 Parameter RECOVERY_CYC, default 2: cycles with cs_n high before the next access.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  access request present.
REQ-008 req_ready  out  1  request accepted this cycle when req_valid is also high.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
REQ-011 req_wdata  in  16  write data.
REQ-012 resp_valid  out  1  one-cycle completion pulse for reads and writes.
REQ-013 resp_rdata  out  16  read data; holds its value until the next read completes.
REQ-014 otg_addr  out  2  HPI address pins.
REQ-015 otg_cs_n, otg_rd_n, otg_wr_n  out  1 each  active-low HPI strobes.
REQ-016 otg_data_out  out  16  HPI data to the pad.
REQ-017 otg_data_oe  out  1  pad output enable.
REQ-018 otg_data_in  in  16  HPI data from the pad.
REQ-019 otg_int  in  1  asynchronous HPI interrupt pin.
REQ-020 irq  out  1  interrupt to the processor.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD and RECOVER; req_ready SHALL be high only in IDLE.
REQ-022 On acceptance (cycle 0), the block SHALL register req_write, req_addr and req_wdata and enter SETUP at cycle 1.
REQ-023 From SETUP through HOLD: otg_cs_n low, otg_addr equal to the latched address, otg_data_oe equal to the latched write flag.
REQ-024 STROBE SHALL drive otg_wr_n low for writes or otg_rd_n low for reads for exactly STROBE_CYC cycles; the other strobe stays high.
REQ-025 Reads SHALL capture otg_data_in into resp_rdata on the last STROBE cycle.
REQ-026 resp_valid SHALL pulse in the first HOLD cycle; with defaults, an access accepted at cycle 0 gives resp_valid at cycle 4 and req_ready high again at cycle 7.
REQ-027 RECOVER SHALL drive otg_cs_n high and otg_data_oe low for RECOVERY_CYC cycles, then return to IDLE.
REQ-028 Each phase SHALL use one down-counter loaded on state entry; phase length equals its parameter exactly.
REQ-029 A parameter value below 1 SHALL cause an elaboration error.
REQ-030 req_valid outside IDLE SHALL be ignored with no side effects.
REQ-031 otg_rd_n and otg_wr_n SHALL never be low at the same time.
REQ-032 otg_data_oe SHALL never be high while otg_rd_n is low.

Reset
REQ-033 Reset SHALL force state IDLE and counters to 0.
REQ-034 Reset SHALL force otg_cs_n, otg_rd_n and otg_wr_n to 1.
REQ-035 Reset SHALL force otg_data_oe, resp_valid and irq to 0, and otg_addr, otg_data_out and resp_rdata to 0.
REQ-036 Reset asserted mid-access SHALL release all strobes asynchronously; no resp_valid is produced for the aborted access.

Configuration
REQ-037 With HPI_INT_SYNC_EN defined, otg_int SHALL pass through a two-flop synchronizer, and irq SHALL be that synchronized level (latency 2 cycles).
REQ-038 With HPI_INT_SYNC_EN undefined, irq SHALL equal otg_int combinationally.

Structure
REQ-039 Package hpi_pkg SHALL hold the FSM state enum and the HPI register address constants (HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3).
REQ-040 The synchronizer SHALL be sub-module hpi_sync2, instantiated only under HPI_INT_SYNC_EN.

Verification
REQ-041 Write addr=2, data=0x1234, defaults -> cs_n low cycles 1-4; wr_n low cycles 2-3; otg_data_out=0x1234 with oe high cycles 1-4; resp_valid at cycle 4.
REQ-042 Read addr=0 with otg_data_in=0xBEEF -> rd_n low cycles 2-3, oe low throughout, resp_rdata=0xBEEF at cycle 4, req_ready high at cycle 7.
REQ-043 Back-to-back requests with req_valid held -> second accepted at cycle 7; cs_n high cycles 5-6.
REQ-044 Reset pulsed during STROBE of a write -> wr_n and cs_n high immediately, oe low, no resp_valid, req_ready high after release.
REQ-045 STROBE_CYC=4, SETUP_CYC=3 -> strobe low exactly 4 cycles starting at cycle 4; rd_n/wr_n overlap never observed.
REQ-046 otg_int rising edge with HPI_INT_SYNC_EN -> irq rises 2 cycles later; without the macro -> irq rises in the same cycle.
